// File: rtl/inexrecur_loader_if.sv
// Host entry stream and regfile_InexRecur random-write port bundled for inexrecur_loader.
// The slave modport is the loader's view; the master modport is the host/regfile side.
interface inexrecur_loader_if #(
    parameter int ADDR_W = 12,
    parameter int DATA_W = 32
);
    logic              in_valid_i;
    logic [DATA_W-1:0] in_data_i;
    logic              in_ready_o;
    logic              ran_we_o;
    logic [ADDR_W-1:0] ran_w_addr_o;
    logic [DATA_W-1:0] ran_w_data_o;

    modport slave (
        input  in_valid_i,
        input  in_data_i,
        output in_ready_o,
        output ran_we_o,
        output ran_w_addr_o,
        output ran_w_data_o
    );

    modport master (
        output in_valid_i,
        output in_data_i,
        input  in_ready_o,
        input  ran_we_o,
        input  ran_w_addr_o,
        input  ran_w_data_o
    );
endinterface

// File: rtl/inexrecur_loader.sv
// Loads a session of entries into regfile_InexRecur at consecutive addresses, then pulses is_start.
// Optional running-XOR checksum output enabled by INEXRECUR_LOADER_CKSUM_EN.
module inexrecur_loader #(
    parameter int ADDR_W    = 12,
    parameter int DATA_W    = 32,
    parameter int DEPTH     = 4096,
    parameter int BASE_ADDR = 0
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   load_req_i,
    input  logic [ADDR_W:0]        load_cnt_i,
    input  logic                   load_abort_i,
    inexrecur_loader_if.slave      bus,
    output logic                   is_start_o,
    output logic                   busy_o,
    output logic                   done_o,
    output logic                   err_o,
`ifdef INEXRECUR_LOADER_CKSUM_EN
    output logic [DATA_W-1:0]      cksum_o,
`endif
    output logic [1:0]             dbg_state_o
);
    localparam int CNT_W = ADDR_W + 1;
    localparam logic [CNT_W-1:0]  DEPTH_C = CNT_W'(DEPTH);
    localparam logic [ADDR_W-1:0] BASE_C  = ADDR_W'(BASE_ADDR);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_LOAD  = 2'd1,
        S_DRAIN = 2'd2,
        S_START = 2'd3
    } state_t;

    // Handshake: an entry transfers on a rising clk edge where in_valid_i && in_ready_o;
    // in_ready_o depends only on the state register, never on in_valid_i.
    state_t            state_q, state_d;
    logic [CNT_W-1:0]  remaining_q, remaining_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] waddr_q, waddr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              err_q, err_d;
    logic [DATA_W-1:0] cksum_q, cksum_d;
    logic              accept;

    assign accept = (state_q == S_LOAD) && bus.in_valid_i;

    always_comb begin
        state_d     = state_q;
        remaining_d = remaining_q;
        addr_d      = addr_q;
        we_d        = 1'b0;
        waddr_d     = waddr_q;
        wdata_d     = wdata_q;
        err_d       = 1'b0;
        cksum_d     = cksum_q;
        case (state_q)
            S_IDLE: begin
                if (load_req_i) begin
                    if ((load_cnt_i == '0) || (load_cnt_i > DEPTH_C)) begin
                        err_d = 1'b1;
                    end else begin
                        state_d     = S_LOAD;
                        remaining_d = load_cnt_i;
                        addr_d      = BASE_C;
                        cksum_d     = '0;
                    end
                end
            end
            S_LOAD: begin
                if (accept) begin
                    we_d        = 1'b1;
                    waddr_d     = addr_q;
                    wdata_d     = bus.in_data_i;
                    addr_d      = addr_q + ADDR_W'(1);
                    remaining_d = remaining_q - CNT_W'(1);
                    cksum_d     = cksum_q ^ bus.in_data_i;
                end
                // Abort outranks completion; the entry accepted alongside it is still written.
                if (load_abort_i) begin
                    state_d = S_IDLE;
                    err_d   = 1'b1;
                end else if (accept && (remaining_q == CNT_W'(1))) begin
                    state_d = S_DRAIN;
                end
            end
            S_DRAIN: state_d = S_START;
            S_START: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            remaining_q <= '0;
            addr_q      <= '0;
            we_q        <= 1'b0;
            waddr_q     <= '0;
            wdata_q     <= '0;
            err_q       <= 1'b0;
            cksum_q     <= '0;
        end else begin
            state_q     <= state_d;
            remaining_q <= remaining_d;
            addr_q      <= addr_d;
            we_q        <= we_d;
            waddr_q     <= waddr_d;
            wdata_q     <= wdata_d;
            err_q       <= err_d;
            cksum_q     <= cksum_d;
        end
    end

    assign bus.in_ready_o   = (state_q == S_LOAD);
    assign bus.ran_we_o     = we_q;
    assign bus.ran_w_addr_o = waddr_q;
    assign bus.ran_w_data_o = wdata_q;
    assign is_start_o       = (state_q == S_START);
    assign done_o           = (state_q == S_START);
    assign busy_o           = (state_q != S_IDLE);
    assign err_o            = err_q;
    assign dbg_state_o      = state_q;

`ifdef INEXRECUR_LOADER_CKSUM_EN
    assign cksum_o = cksum_q;
`else
    logic unused_cksum;
    assign unused_cksum = ^cksum_q;
`endif
endmodule

// File: tb/tb_inexrecur_loader.sv
// Bench for inexrecur_loader: two instances (BASE_ADDR 0 and 4094) driven with identical stimulus.
module tb_inexrecur_loader;
    localparam int ADDR_W = 12;
    localparam int DATA_W = 32;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              load_req = 1'b0;
    logic [ADDR_W:0]   load_cnt = '0;
    logic              load_abort = 1'b0;
    logic              in_valid = 1'b0;
    logic [DATA_W-1:0] in_data = '0;

    logic              ready_w [2];
    logic              we_w    [2];
    logic [ADDR_W-1:0] addr_w  [2];
    logic [DATA_W-1:0] data_w  [2];
    logic              start_w [2];
    logic              busy_w  [2];
    logic              done_w  [2];
    logic              err_w   [2];
    logic [1:0]        dbg_w   [2];
`ifdef INEXRECUR_LOADER_CKSUM_EN
    logic [DATA_W-1:0] cksum_w [2];
`endif

    int checks = 0;
    int failures = 0;
    logic [DATA_W-1:0] data_q[$];

    always #5 clk = ~clk;

    for (genvar g = 0; g < 2; g++) begin : g_dut
        inexrecur_loader_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_if ();
        assign u_if.in_valid_i = in_valid;
        assign u_if.in_data_i  = in_data;
        assign ready_w[g] = u_if.in_ready_o;
        assign we_w[g]    = u_if.ran_we_o;
        assign addr_w[g]  = u_if.ran_w_addr_o;
        assign data_w[g]  = u_if.ran_w_data_o;

        inexrecur_loader #(
            .ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(4096),
            .BASE_ADDR((g == 1) ? 4094 : 0)
        ) u_dut (
            .clk          (clk),
            .rst_n        (rst_n),
            .load_req_i   (load_req),
            .load_cnt_i   (load_cnt),
            .load_abort_i (load_abort),
            .bus          (u_if.slave),
            .is_start_o   (start_w[g]),
            .busy_o       (busy_w[g]),
            .done_o       (done_w[g]),
            .err_o        (err_w[g]),
`ifdef INEXRECUR_LOADER_CKSUM_EN
            .cksum_o      (cksum_w[g]),
`endif
            .dbg_state_o  (dbg_w[g])
        );
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input int d, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s dut%0d actual=0x%0h expected=0x%0h", nm, d, act, exp);
        end
    endtask

    function automatic int base_of(input int d);
        return (d == 1) ? 4094 : 0;
    endfunction

    // Compare every observable output of both instances against the expected cycle picture.
    task automatic chk_cycle(input bit e_ready, input bit e_busy, input bit e_start, input bit e_err,
                             input bit e_we, input int off, input logic [DATA_W-1:0] e_data);
        for (int d = 0; d < 2; d++) begin
            chk("in_ready", d, ready_w[d], e_ready);
            chk("busy", d, busy_w[d], e_busy);
            chk("is_start", d, start_w[d], e_start);
            chk("done", d, done_w[d], e_start);
            chk("err", d, err_w[d], e_err);
            chk("ran_we", d, we_w[d], e_we);
            if (e_we) begin
                chk("ran_w_addr", d, addr_w[d], (base_of(d) + off) % 4096);
                chk("ran_w_data", d, data_w[d], e_data);
            end
        end
    endtask

    // mode 0: valid every cycle, 1: valid on even beats, 2: random valid.
    // abort_idx: abort asserted together with that accepted entry (0 = never).
    task automatic run_session(input int cnt, input int mode, input int abort_idx);
        int accepted = 0;
        int beat = 0;
        int last_off = 0;
        bit prev_acc = 1'b0;
        bit aborted = 1'b0;
        bit v;
        logic [DATA_W-1:0] dat;
        logic [DATA_W-1:0] last_dat = '0;
        logic [DATA_W-1:0] x = '0;
        load_req = 1'b1;
        load_cnt = (ADDR_W+1)'(cnt);
        step();
        load_req = 1'b0;
        while (accepted < cnt && !aborted) begin
            chk_cycle(1'b1, 1'b1, 1'b0, 1'b0, prev_acc, last_off, last_dat);
            case (mode)
                0:       v = 1'b1;
                1:       v = (beat % 2 == 0);
                default: v = 1'($urandom_range(0, 1));
            endcase
            dat = $urandom;
            if (v && data_q.size() > 0) dat = data_q.pop_front();
            in_valid   = v;
            in_data    = dat;
            load_abort = 1'b0;
            if (v) begin
                last_off = accepted;
                last_dat = dat;
                accepted++;
                x ^= dat;
                if (accepted == abort_idx) begin
                    load_abort = 1'b1;
                    aborted = 1'b1;
                end
            end
            prev_acc = v;
            beat++;
            step();
            if (beat > 20000) begin
                checks++;
                failures++;
                $display("FAIL session_timeout dut0 actual=%0d expected<=20000", beat);
                break;
            end
        end
        in_valid   = 1'b0;
        load_abort = 1'b0;
        chk_cycle(1'b0, !aborted, 1'b0, aborted, 1'b1, last_off, last_dat);
        step();
        chk_cycle(1'b0, !aborted, !aborted, 1'b0, 1'b0, 0, '0);
`ifdef INEXRECUR_LOADER_CKSUM_EN
        if (!aborted) begin
            for (int d = 0; d < 2; d++) chk("cksum", d, cksum_w[d], x);
        end
`endif
        step();
        chk_cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0, '0);
    endtask

    typedef struct {
        logic [ADDR_W:0] cnt;
        logic            exp_err;
        logic            exp_busy;
    } req_vec_t;

    initial begin
        req_vec_t vecs[6];
        vecs[0] = '{cnt: 13'd0,    exp_err: 1'b1, exp_busy: 1'b0};
        vecs[1] = '{cnt: 13'd4097, exp_err: 1'b1, exp_busy: 1'b0};
        vecs[2] = '{cnt: 13'd8191, exp_err: 1'b1, exp_busy: 1'b0};
        vecs[3] = '{cnt: 13'd1,    exp_err: 1'b0, exp_busy: 1'b1};
        vecs[4] = '{cnt: 13'd4096, exp_err: 1'b0, exp_busy: 1'b1};
        vecs[5] = '{cnt: 13'd2,    exp_err: 1'b0, exp_busy: 1'b1};

        // Reset and idle picture
        rst_n = 1'b0;
        step();
        step();
        for (int d = 0; d < 2; d++) begin
            chk("rst_addr", d, addr_w[d], 0);
            chk("rst_data", d, data_w[d], 0);
        end
        rst_n = 1'b1;
        step();
        chk_cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0, '0);
        load_abort = 1'b1;
        step();
        load_abort = 1'b0;
        chk_cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0, '0);

        // Request validation table
        for (int i = 0; i < 6; i++) begin
            load_req = 1'b1;
            load_cnt = vecs[i].cnt;
            step();
            load_req = 1'b0;
            chk_cycle(vecs[i].exp_busy, vecs[i].exp_busy, 1'b0, vecs[i].exp_err, 1'b0, 0, '0);
            if (vecs[i].exp_busy) begin
                load_req = 1'b1;
                load_cnt = '0;
                step();
                load_req = 1'b0;
                chk_cycle(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 0, '0);
                load_abort = 1'b1;
                step();
                load_abort = 1'b0;
                chk_cycle(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 0, '0);
            end
            step();
            chk_cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0, '0);
        end

        // Directed sessions
        data_q = '{32'h11, 32'h22, 32'h33};
        run_session(3, 0, 0);
        run_session(4, 1, 0);
        run_session(4, 0, 0);
        run_session(5, 0, 2);
        data_q = '{32'hF0F0F0F0, 32'h0F0F0F0F};
        run_session(2, 0, 0);
        run_session(1, 0, 0);
        run_session(4096, 0, 0);

        // Reset mid-LOAD drops the session
        load_req = 1'b1;
        load_cnt = 13'd5;
        step();
        load_req = 1'b0;
        in_valid = 1'b1;
        in_data  = 32'hA5A5_0001;
        step();
        in_data  = 32'hA5A5_0002;
        step();
        in_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        chk_cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0, '0);
        for (int d = 0; d < 2; d++) begin
            chk("midrst_addr", d, addr_w[d], 0);
            chk("midrst_data", d, data_w[d], 0);
        end
        #1;
        rst_n = 1'b1;
        for (int c = 0; c < 4; c++) begin
            step();
            chk_cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0, '0);
        end

        // Randomized sessions against the model
        for (int s = 0; s < 12; s++) begin
            int n;
            int ab;
            n = $urandom_range(1, 24);
            ab = ($urandom_range(0, 3) == 0) ? $urandom_range(1, n) : 0;
            run_session(n, $urandom_range(0, 2), ab);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
